if_id_hazard_reg: RTL and testbench
===================================

Name: if_id_hazard_reg

Overview:
IF/ID pipeline register combined with the hazard detection unit of the 5-stage MIPS pipeline.
- Latches the fetched instruction and PC+4 from the IF stage and presents them to ID.
- Detects load-use and branch-operand hazards against the ID/EX and EX/MEM stages.
- Drives PC_Write back to IF, holds IF/ID on a stall, and injects an ID/EX bubble.
- Squashes the wrong-path instruction on a taken branch and keeps saturating stall/flush event counters.

Parameters:
CNT_W, 16, width of stall/flush event counters
NOP_INSTR, 32'h0000_0000, instruction word inserted on reset/flush

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
instr_i  input  32  instruction from IF
pc_plus4_i  input  32  PC+4 from IF
branch_taken_i  input  1  branch resolved taken in ID (from IF)
ex_mem_read_i  input  1  instruction in EX is a load
ex_reg_write_i  input  1  instruction in EX writes a register
ex_rd_i  input  5  destination register of EX instruction
mem_mem_read_i  input  1  instruction in MEM is a load
mem_rd_i  input  5  destination register of MEM instruction
instr_o  output  32  IF/ID instruction to ID
pc_plus4_o  output  32  IF/ID PC+4 to ID
valid_o  output  1  IF/ID holds a real instruction
PC_Write_o  output  1  1 = IF may advance PC; 0 = stall
id_stall_o  output  1  ID must zero control signals into ID/EX and must not assert Branch
stall_cnt_o  output  CNT_W  stall cycles counted, saturating
flush_cnt_o  output  CNT_W  flushes counted, saturating

Behaviour:
- Reset (rst_n=0 at posedge clk): instr_o=NOP_INSTR, pc_plus4_o=0, valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Reset mid-stall clears everything; the first cycle after reset has no stall.
- Decode of instr_o (ID stage): op=[31:26], rs=[25:21], rt=[20:16].
  - Source usage: op 0x00 (R-type) rs,rt; 0x04 beq rs,rt; 0x2B sw rs,rt; 0x23 lw rs; 0x08 addi rs; all other opcodes use none.
- Match rule: match(r) = (r != 0) && (r == used source register); it is evaluated only when valid_o=1.
- Hazard conditions (combinational; the stall is their OR):
  - H1 load-use: ex_mem_read_i && match(ex_rd_i), any instruction type.
  - H2 branch-ALU: op==beq && ex_reg_write_i && !ex_mem_read_i && match(ex_rd_i).
  - H3 branch-load in MEM: op==beq && mem_mem_read_i && match(mem_rd_i).
  - Net effect: beq after lw stalls 2 cycles (H1, then H3); beq after ALU op stalls 1 cycle; other uses after lw stall 1 cycle.
- Outputs from stall: PC_Write_o = !stall; id_stall_o = stall. Both are purely combinational and there is no registered latency on them.
- Register update at posedge clk when rst_n=1, in priority order:
  1. stall=1: instr_o, pc_plus4_o and valid_o hold; branch_taken_i is ignored; stall_cnt_o increments.
  2. branch_taken_i=1: instr_o=NOP_INSTR, pc_plus4_o=0, valid_o=0; flush_cnt_o increments.
  3. Otherwise: instr_o=instr_i, pc_plus4_o=pc_plus4_i, valid_o=1.
- Counters: both saturate at 2^CNT_W-1 and never wrap.
- A flushed slot (valid_o=0) never raises a stall, even if instr bits would match.
- Total stall latency is bounded at 2 cycles per instruction.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with instr_i=0x8D280000 -> instr_o=0, valid_o=0, PC_Write_o=1, both counters 0.
- Load-use: lw $8,0($9) (0x8D280000), then add $10,$8,$11 (0x010B5020) in ID with ex_mem_read_i=1, ex_rd_i=8 -> PC_Write_o=0 for exactly 1 cycle, instr_o held at 0x010B5020, stall_cnt_o=1.
- Branch after load: beq $8,$11 (0x110B0003) in ID, ex_mem_read_i=1/ex_rd_i=8, next cycle mem_mem_read_i=1/mem_rd_i=8 -> 2 stall cycles, stall_cnt_o=2.
- Branch after ALU: ex_reg_write_i=1, ex_rd_i=11, beq 0x110B0003 in ID -> 1 stall cycle. Then branch_taken_i=1 -> instr_o=0, valid_o=0, flush_cnt_o=1.
- $0 and no-match: ex_mem_read_i=1 with ex_rd_i=0, or ex_rd_i=5 against add 0x010B5020 -> no stall, PC_Write_o=1 throughout.
- Simultaneous and saturation: stall active and branch_taken_i=1 on the same edge -> registers held, flush_cnt_o unchanged. With CNT_W=2, 5 stalls -> stall_cnt_o=3.

Source files
------------

// File: rtl/if_id_hazard_reg.sv
// ============================================================================
// Module   : if_id_hazard_reg
// Purpose  : IF/ID pipeline register with load-use / branch-operand hazard
//            detection, stall/flush control and saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_hazard_reg #(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_plus4_i,
    input  logic             branch_taken_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             mem_mem_read_i,
    input  logic [4:0]       mem_rd_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_plus4_o,
    output logic             valid_o,
    output logic             PC_Write_o,
    output logic             id_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [5:0]       c_op_rtype = 6'h00;
    localparam logic [5:0]       c_op_beq   = 6'h04;
    localparam logic [5:0]       c_op_addi  = 6'h08;
    localparam logic [5:0]       c_op_lw    = 6'h23;
    localparam logic [5:0]       c_op_sw    = 6'h2B;
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    logic [31:0]      r_instr;
    logic [31:0]      r_pc_plus4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_is_beq;
    logic       w_h1;
    logic       w_h2;
    logic       w_h3;
    logic       w_stall;

    assign w_op     = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_is_beq = (w_op == c_op_beq);

    always_comb begin
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        case (w_op)
            c_op_rtype, c_op_beq, c_op_sw: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            c_op_lw, c_op_addi: w_uses_rs = 1'b1;
            default: ;
        endcase
    end

    // $0 is hard-wired zero and never creates a true dependency.
    function automatic logic f_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rs,
                                     input logic       use_rt);
        return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
    endfunction

    assign w_h1 = ex_mem_read_i &&
                  f_match(ex_rd_i, w_rs, w_rt, w_uses_rs, w_uses_rt);
    assign w_h2 = w_is_beq && ex_reg_write_i && !ex_mem_read_i &&
                  f_match(ex_rd_i, w_rs, w_rt, w_uses_rs, w_uses_rt);
    assign w_h3 = w_is_beq && mem_mem_read_i &&
                  f_match(mem_rd_i, w_rs, w_rt, w_uses_rs, w_uses_rt);

    // A flushed slot carries no instruction, so it can never stall.
    assign w_stall = r_valid && (w_h1 || w_h2 || w_h3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr     <= NOP_INSTR;
            r_pc_plus4  <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_stall) begin
            // Stall wins over a taken branch: the branch decision is stale.
            if (r_stall_cnt != c_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else if (branch_taken_i) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
            if (r_flush_cnt != c_cnt_max) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end else begin
            r_instr    <= instr_i;
            r_pc_plus4 <= pc_plus4_i;
            r_valid    <= 1'b1;
        end
    end

    assign instr_o     = r_instr;
    assign pc_plus4_o  = r_pc_plus4;
    assign valid_o     = r_valid;
    assign PC_Write_o  = !w_stall;
    assign id_stall_o  = w_stall;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_if_id_hazard_reg.sv
// ============================================================================
// Module   : tb_if_id_hazard_reg
// Purpose  : Directed self-checking bench for if_id_hazard_reg with a queue
//            of expected output snapshots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_hazard_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic [31:0] pc_plus4_i;
    logic        branch_taken_i;
    logic        ex_mem_read_i;
    logic        ex_reg_write_i;
    logic [4:0]  ex_rd_i;
    logic        mem_mem_read_i;
    logic [4:0]  mem_rd_i;

    logic [31:0] instr_o, instr_o2;
    logic [31:0] pc_plus4_o, pc_plus4_o2;
    logic        valid_o, valid_o2;
    logic        PC_Write_o, PC_Write_o2;
    logic        id_stall_o, id_stall_o2;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic [1:0]  stall_cnt_o2, flush_cnt_o2;

    always #5 clk = ~clk;

    if_id_hazard_reg #(.CNT_W(16), .NOP_INSTR(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
        .branch_taken_i(branch_taken_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i),
        .mem_mem_read_i(mem_mem_read_i), .mem_rd_i(mem_rd_i),
        .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
        .PC_Write_o(PC_Write_o), .id_stall_o(id_stall_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    if_id_hazard_reg #(.CNT_W(2), .NOP_INSTR(32'h0000_0000)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
        .branch_taken_i(branch_taken_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i),
        .mem_mem_read_i(mem_mem_read_i), .mem_rd_i(mem_rd_i),
        .instr_o(instr_o2), .pc_plus4_o(pc_plus4_o2), .valid_o(valid_o2),
        .PC_Write_o(PC_Write_o2), .id_stall_o(id_stall_o2),
        .stall_cnt_o(stall_cnt_o2), .flush_cnt_o(flush_cnt_o2)
    );

    typedef struct {
        int          step;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        pcw;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic [1:0]  scnt2;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step     = 0;

    localparam logic [31:0] c_lw   = 32'h8D28_0000;
    localparam logic [31:0] c_add  = 32'h010B_5020;
    localparam logic [31:0] c_beq  = 32'h110B_0003;
    localparam logic [31:0] c_addi = 32'h2109_0004;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL step%0d %s: observed %h expected %h", step, name, obs, expv);
        end
    endtask

    task automatic drive(input logic rn, input logic [31:0] ins, input logic [31:0] pc,
                         input logic bt, input logic exmr, input logic exrw,
                         input logic [4:0] exrd, input logic mmr, input logic [4:0] mrd);
        rst_n          = rn;
        instr_i        = ins;
        pc_plus4_i     = pc;
        branch_taken_i = bt;
        ex_mem_read_i  = exmr;
        ex_reg_write_i = exrw;
        ex_rd_i        = exrd;
        mem_mem_read_i = mmr;
        mem_rd_i       = mrd;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic pcw, input logic [15:0] scnt, input logic [15:0] fcnt);
        exp_t e;
        e.step  = step;
        e.instr = ins;
        e.pc    = pc;
        e.valid = v;
        e.pcw   = pcw;
        e.scnt  = scnt;
        e.fcnt  = fcnt;
        e.scnt2 = (scnt > 16'd3) ? 2'd3 : scnt[1:0];
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL step%0d scoreboard: observed empty queue expected entry", step);
        end else begin
            e = exp_q.pop_front();
            chk("instr_o",     instr_o,            e.instr);
            chk("pc_plus4_o",  pc_plus4_o,         e.pc);
            chk("valid_o",     {31'd0, valid_o},   {31'd0, e.valid});
            chk("PC_Write_o",  {31'd0, PC_Write_o},{31'd0, e.pcw});
            chk("id_stall_o",  {31'd0, id_stall_o},{31'd0, !e.pcw});
            chk("stall_cnt_o", {16'd0, stall_cnt_o}, {16'd0, e.scnt});
            chk("flush_cnt_o", {16'd0, flush_cnt_o}, {16'd0, e.fcnt});
            chk("stall_cnt_sat", {30'd0, stall_cnt_o2}, {30'd0, e.scnt2});
        end
    endtask

    // One cycle: drive inputs on the falling edge, record expected, compare.
    task automatic cyc(input logic rn, input logic [31:0] ins, input logic [31:0] pc,
                       input logic bt, input logic exmr, input logic exrw,
                       input logic [4:0] exrd, input logic mmr, input logic [4:0] mrd,
                       input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_v,
                       input logic e_pcw, input logic [15:0] e_s, input logic [15:0] e_f);
        @(negedge clk);
        step++;
        drive(rn, ins, pc, bt, exmr, exrw, exrd, mmr, mrd);
        push(e_ins, e_pc, e_v, e_pcw, e_s, e_f);
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, c_lw, 32'd4, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        // reset held two cycles
        cyc(1'b0, c_lw, 32'd4,  0, 0, 0, 5'd0,  0, 5'd0,  32'd0,  32'd0, 0, 1, 16'd0, 16'd0);
        cyc(1'b1, c_lw, 32'd4,  0, 0, 0, 5'd0,  0, 5'd0,  32'd0,  32'd0, 0, 1, 16'd0, 16'd0);
        // lw in ID, add arrives
        cyc(1'b1, c_add, 32'd8, 0, 0, 0, 5'd0,  0, 5'd0,  c_lw,   32'd4, 1, 1, 16'd0, 16'd0);
        // load-use: add in ID, lw in EX
        cyc(1'b1, c_beq, 32'd12, 0, 1, 1, 5'd8, 0, 5'd0,  c_add,  32'd8, 1, 0, 16'd0, 16'd0);
        // lw in MEM: add is not a branch, no further stall
        cyc(1'b1, c_beq, 32'd12, 0, 0, 0, 5'd0, 1, 5'd8,  c_add,  32'd8, 1, 1, 16'd1, 16'd0);
        // beq after lw: H1 then H3
        cyc(1'b1, c_beq, 32'd16, 0, 1, 1, 5'd8, 0, 5'd0,  c_beq, 32'd12, 1, 0, 16'd1, 16'd0);
        cyc(1'b1, c_beq, 32'd16, 0, 0, 0, 5'd0, 1, 5'd8,  c_beq, 32'd12, 1, 0, 16'd2, 16'd0);
        cyc(1'b1, c_beq, 32'd16, 0, 0, 0, 5'd0, 0, 5'd0,  c_beq, 32'd12, 1, 1, 16'd3, 16'd0);
        // beq after ALU write of $11, with a simultaneous taken branch
        cyc(1'b1, c_lw, 32'd20,  1, 0, 1, 5'd11, 0, 5'd0, c_beq, 32'd16, 1, 0, 16'd3, 16'd0);
        // dependency gone, branch taken: flush the wrong-path fetch
        cyc(1'b1, c_lw, 32'd20,  1, 0, 0, 5'd0, 0, 5'd0,  c_beq, 32'd16, 1, 1, 16'd4, 16'd0);
        // flushed slot: no stall even with a load in EX
        cyc(1'b1, c_add, 32'd24, 0, 1, 0, 5'd0, 0, 5'd0,  32'd0,  32'd0, 0, 1, 16'd4, 16'd1);
        // $0 destination never matches
        cyc(1'b1, c_add, 32'd28, 0, 1, 0, 5'd0, 0, 5'd0,  c_add, 32'd24, 1, 1, 16'd4, 16'd1);
        // unrelated destination register
        cyc(1'b1, c_addi, 32'd32, 0, 1, 0, 5'd5, 0, 5'd0, c_add, 32'd28, 1, 1, 16'd4, 16'd1);
        // addi does not read rt ($9)
        cyc(1'b1, c_add, 32'd36, 0, 1, 0, 5'd9, 0, 5'd0,  c_addi, 32'd32, 1, 1, 16'd4, 16'd1);
        // reset asserted while a load-use stall is active
        cyc(1'b0, c_add, 32'd40, 0, 1, 0, 5'd8, 0, 5'd0,  c_add, 32'd36, 1, 0, 16'd4, 16'd1);
        cyc(1'b1, c_add, 32'd40, 0, 1, 0, 5'd8, 0, 5'd0,  32'd0,  32'd0, 0, 1, 16'd0, 16'd0);
        // five consecutive stall cycles
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, c_add, 32'd44, 0, 1, 0, 5'd8, 0, 5'd0,
                c_add, 32'd40, 1, 0, 16'(i), 16'd0);
        end
        cyc(1'b1, c_add, 32'd44, 0, 0, 0, 5'd0, 0, 5'd0,  c_add, 32'd40, 1, 1, 16'd5, 16'd0);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
